// File: rtl/cpu_port_arbiter_pkg.sv
// Shared types and helpers for the CPU port arbiter.
//   arb_state_e : arbiter FSM states
//   wd_width    : watchdog counter width for a given timeout (never zero)
//   rr_wrap     : (base + k) mod n, used by the round-robin search
package cpu_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RELEASE
    } arb_state_e;

    // A disabled watchdog (timeout 0) still gets a 1-bit counter so no
    // zero-width vectors appear anywhere.
    function automatic int wd_width(input int timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

    function automatic int rr_wrap(input int base, input int k, input int n);
        return (base + k) % n;
    endfunction

endpackage

// File: rtl/cpu_port_arbiter_if.sv
// Bus bundle between N CPU request ports, the arbiter and the cache's
// single CPU request/response path.
//   req_*      : per-port requests (port i at index i)
//   rsp_*      : per-port completion pulses and shared read data
//   mem_req_*  : the one request presented to the memory system
//   mem_rsp_*  : the memory system's hit/read-data response
// Modports:
//   slave  : the arbiter (serves CPU ports, drives the memory request)
//   master : the surrounding system (CPU ports plus memory responder)
interface cpu_port_arbiter_if #(
    parameter int N_PORTS = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int STRB_W  = DATA_W / 8
);
    logic [N_PORTS-1:0]             req_valid;
    logic [N_PORTS-1:0][ADDR_W-1:0] req_addr;
    logic [N_PORTS-1:0][DATA_W-1:0] req_data;
    logic [N_PORTS-1:0]             req_wen;
    logic [N_PORTS-1:0][STRB_W-1:0] req_strobe;

    logic [N_PORTS-1:0]             rsp_hit;
    logic [N_PORTS-1:0]             rsp_err;
    logic [DATA_W-1:0]              rsp_rdata;

    logic                           mem_req_valid;
    logic [ADDR_W-1:0]              mem_req_addr;
    logic [DATA_W-1:0]              mem_req_data;
    logic                           mem_req_wen;
    logic [STRB_W-1:0]              mem_req_strobe;
    logic                           mem_rsp_hit;
    logic [DATA_W-1:0]              mem_rsp_rdata;

    modport slave (
        input  req_valid, req_addr, req_data, req_wen, req_strobe,
        input  mem_rsp_hit, mem_rsp_rdata,
        output rsp_hit, rsp_err, rsp_rdata,
        output mem_req_valid, mem_req_addr, mem_req_data, mem_req_wen, mem_req_strobe
    );

    modport master (
        output req_valid, req_addr, req_data, req_wen, req_strobe,
        output mem_rsp_hit, mem_rsp_rdata,
        input  rsp_hit, rsp_err, rsp_rdata,
        input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_wen, mem_req_strobe
    );

endinterface

// File: rtl/cpu_port_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : last granted index; search starts at ptr+1 and wraps
//   grant : one-hot winner (all zero when no request)
//   idx   : winner index
//   any   : at least one request present
module cpu_port_arbiter_rr_pick
    import cpu_port_arbiter_pkg::*;
#(
    parameter int N_PORTS = 4,
    localparam int IDX_W  = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [N_PORTS-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    // Offsets 1..N visit every port once, ending on ptr itself so a lone
    // requester that was just served can still win again.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N_PORTS; k++) begin
            cand = IDX_W'(rr_wrap(int'(ptr), k, N_PORTS));
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_port_arbiter.sv
// Round-robin front end sharing one cache request path among N CPU ports.
// One transaction in flight; the winning request is captured into mem_req_*
// and held until the memory hits or the watchdog aborts it.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response bundle (slave view)
//   grant_id   : current or most recent granted port
//   busy       : FSM not idle
module cpu_port_arbiter
    import cpu_port_arbiter_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int STRB_W  = DATA_W / 8,
    parameter int TIMEOUT = 1024,
    localparam int IDX_W  = $clog2(N_PORTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    cpu_port_arbiter_if.slave bus,
    output logic [IDX_W-1:0]  grant_id,
    output logic              busy
);

    localparam int               WD_W   = wd_width(TIMEOUT);
    localparam logic [WD_W-1:0]  WD_MAX = '1;

    arb_state_e          state;
    logic [IDX_W-1:0]    ptr;
    logic [N_PORTS-1:0]  gnt_oh;
    logic [WD_W-1:0]     wd;
    logic                wd_expire;

    logic [N_PORTS-1:0]  pick_oh;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;

    cpu_port_arbiter_rr_pick #(.N_PORTS(N_PORTS)) u_pick (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (pick_oh),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign wd_expire = (TIMEOUT != 0) && (wd == WD_W'(TIMEOUT - 1));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            ptr                <= IDX_W'(N_PORTS - 1);
            gnt_oh             <= '0;
            grant_id           <= '0;
            wd                 <= '0;
            bus.mem_req_valid  <= 1'b0;
            bus.mem_req_addr   <= '0;
            bus.mem_req_data   <= '0;
            bus.mem_req_wen    <= 1'b0;
            bus.mem_req_strobe <= '0;
            bus.rsp_hit        <= '0;
            bus.rsp_err        <= '0;
            bus.rsp_rdata      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.rsp_hit   <= '0;
                    bus.rsp_err   <= '0;
                    bus.rsp_rdata <= '0;
                    if (pick_any) begin
                        bus.mem_req_addr   <= bus.req_addr[pick_idx];
                        bus.mem_req_data   <= bus.req_data[pick_idx];
                        bus.mem_req_wen    <= bus.req_wen[pick_idx];
                        bus.mem_req_strobe <= bus.req_strobe[pick_idx];
                        bus.mem_req_valid  <= 1'b1;
                        grant_id           <= pick_idx;
                        ptr                <= pick_idx;
                        gnt_oh             <= pick_oh;
                        wd                 <= '0;
                        state              <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (wd != WD_MAX) wd <= wd + 1'b1;
                    // A hit in the expiry cycle still counts as a clean hit.
                    if (bus.mem_rsp_hit) begin
                        bus.rsp_hit       <= gnt_oh;
                        bus.rsp_err       <= '0;
                        bus.rsp_rdata     <= bus.mem_rsp_rdata;
                        bus.mem_req_valid <= 1'b0;
                        state             <= RELEASE;
                    end else if (wd_expire) begin
                        bus.rsp_hit       <= gnt_oh;
                        bus.rsp_err       <= gnt_oh;
                        bus.rsp_rdata     <= '0;
                        bus.mem_req_valid <= 1'b0;
                        state             <= RELEASE;
                    end
                end

                RELEASE: begin
                    // Wait for the owner to drop valid so a request still held
                    // after its completion pulse is not issued twice.
                    bus.rsp_hit   <= '0;
                    bus.rsp_err   <= '0;
                    bus.rsp_rdata <= '0;
                    if ((bus.req_valid & gnt_oh) == '0) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_port_arbiter.sv
module tb_cpu_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 8;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_port_arbiter_if #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) bus ();
    logic [IW-1:0] grant_id;
    logic          busy;

    cpu_port_arbiter #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .STRB_W(SW), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy)
    );

    typedef struct {
        int            port;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          wen;
        logic [SW-1:0] strb;
    } iss_t;
    typedef struct {
        int            port;
        logic          err;
        logic [DW-1:0] rdata;
        int            lat;
    } rsp_t;
    typedef struct {
        int            lat;   // ISSUE cycle carrying the hit; 0 = never
        logic          late;  // stale hit one cycle after the request drops
        logic [DW-1:0] rdata;
    } mem_t;

    iss_t exp_iss[$];
    rsp_t exp_rsp[$];
    mem_t mem_cfg[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Expected issue, memory behaviour and response for one transaction,
    // queued in the hand-computed grant order.
    task automatic expect_txn(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic w, input logic [SW-1:0] s, input int lat,
                              input logic late, input logic [DW-1:0] rd, input bit has_rsp);
        iss_t i;
        rsp_t r;
        mem_t m;
        i.port = p; i.addr = a; i.data = d; i.wen = w; i.strb = s;
        exp_iss.push_back(i);
        m.lat = lat; m.late = late; m.rdata = rd;
        mem_cfg.push_back(m);
        if (has_rsp) begin
            r.port  = p;
            r.err   = (lat == 0);
            r.rdata = (lat == 0) ? '0 : rd;
            r.lat   = (lat == 0) ? TO : lat;
            exp_rsp.push_back(r);
        end
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic w, input logic [SW-1:0] s);
        bus.req_addr[p]   = a;
        bus.req_data[p]   = d;
        bus.req_wen[p]    = w;
        bus.req_strobe[p] = s;
        bus.req_valid[p]  = 1'b1;
    endtask

    task automatic wait_hit(input int p);
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.rsp_hit[p]) break;
        end
        chk($sformatf("port%0d_completed", p), 64'(i < 200), 64'd1);
        bus.req_valid[p] = 1'b0;
    endtask

    task automatic do_req(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic w, input logic [SW-1:0] s);
        @(negedge clk);
        set_port(p, a, d, w, s);
        wait_hit(p);
    endtask

    task automatic settle();
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy && exp_iss.size() == 0 && exp_rsp.size() == 0) break;
        end
        chk("settle", 64'(i < 100), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    // Memory responder
    initial begin
        bit   active;
        int   cnt;
        mem_t c;
        active = 0;
        cnt    = 0;
        c      = '{lat: 1, late: 1'b0, rdata: '0};
        bus.mem_rsp_hit   = 1'b0;
        bus.mem_rsp_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_rsp_hit   = 1'b0;
            bus.mem_rsp_rdata = '0;
            if (!rst_n) begin
                active = 0;
            end else if (bus.mem_req_valid) begin
                if (!active) begin
                    active = 1;
                    cnt    = 1;
                    if (mem_cfg.size() > 0) c = mem_cfg.pop_front();
                    else c = '{lat: 1, late: 1'b0, rdata: '0};
                end else begin
                    cnt++;
                end
                if (c.lat == cnt) begin
                    bus.mem_rsp_hit   = 1'b1;
                    bus.mem_rsp_rdata = c.rdata;
                end
            end else if (active) begin
                active = 0;
                if (c.late) begin
                    bus.mem_rsp_hit   = 1'b1;
                    bus.mem_rsp_rdata = 32'hdead_beef;
                end
            end
        end
    end

    // Scoreboard monitor
    initial begin
        iss_t          e;
        rsp_t          r;
        logic          prev_v;
        int            cyc;
        int            iss_cyc;
        logic [N-1:0]  oh;
        prev_v  = 1'b0;
        cyc     = 0;
        iss_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                cyc++;
                if (bus.mem_req_valid && !prev_v) begin
                    iss_cyc = cyc;
                    if (exp_iss.size() == 0) begin
                        chk("unexpected_issue", 64'd1, 64'd0);
                    end else begin
                        e = exp_iss.pop_front();
                        chk("grant_id", 64'(grant_id), 64'(e.port));
                        chk("mem_req_addr", 64'(bus.mem_req_addr), 64'(e.addr));
                        chk("mem_req_data", 64'(bus.mem_req_data), 64'(e.data));
                        chk("mem_req_wen", 64'(bus.mem_req_wen), 64'(e.wen));
                        chk("mem_req_strobe", 64'(bus.mem_req_strobe), 64'(e.strb));
                    end
                end
                prev_v = bus.mem_req_valid;
                if (bus.rsp_hit != '0 || bus.rsp_err != '0) begin
                    if (exp_rsp.size() == 0) begin
                        chk("unexpected_rsp", 64'(bus.rsp_hit), 64'd0);
                    end else begin
                        r  = exp_rsp.pop_front();
                        oh = N'(1) << r.port;
                        chk("rsp_hit", 64'(bus.rsp_hit), 64'(oh));
                        chk("rsp_err", 64'(bus.rsp_err), r.err ? 64'(oh) : 64'd0);
                        chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(r.rdata));
                        chk("rsp_latency", 64'(cyc - iss_cyc), 64'(r.lat));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    // Stimulus
    initial begin
        bus.req_valid  = '0;
        bus.req_addr   = '0;
        bus.req_data   = '0;
        bus.req_wen    = '0;
        bus.req_strobe = '0;

        #12;
        chk("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_rsp_hit", 64'(bus.rsp_hit), 64'd0);
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("rst_mem_req_addr", 64'(bus.mem_req_addr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // All four ports at once from reset: 0,1,2,3
        expect_txn(0, 32'h00, '0, 1'b0, 4'h0, 1, 1'b0, 32'h1000_0000, 1);
        expect_txn(1, 32'h10, '0, 1'b0, 4'h0, 2, 1'b0, 32'h1000_0001, 1);
        expect_txn(2, 32'h20, '0, 1'b0, 4'h0, 3, 1'b0, 32'h1000_0002, 1);
        expect_txn(3, 32'h30, '0, 1'b0, 4'h0, 1, 1'b0, 32'h1000_0003, 1);
        fork
            do_req(0, 32'h00, '0, 1'b0, 4'h0);
            do_req(1, 32'h10, '0, 1'b0, 4'h0);
            do_req(2, 32'h20, '0, 1'b0, 4'h0);
            do_req(3, 32'h30, '0, 1'b0, 4'h0);
        join
        settle();

        // Ports 1 and 3 again: 1 then 3
        expect_txn(1, 32'h44, '0, 1'b0, 4'h0, 2, 1'b0, 32'h2000_0001, 1);
        expect_txn(3, 32'h48, '0, 1'b0, 4'h0, 1, 1'b0, 32'h2000_0003, 1);
        fork
            do_req(1, 32'h44, '0, 1'b0, 4'h0);
            do_req(3, 32'h48, '0, 1'b0, 4'h0);
        join
        settle();

        // Ports 2 and 3 with ptr=3: wrap past empty 0 and 1
        expect_txn(2, 32'h80, '0, 1'b0, 4'h0, 2, 1'b0, 32'ha5a5_0002, 1);
        expect_txn(3, 32'h84, '0, 1'b0, 4'h0, 4, 1'b0, 32'ha5a5_0003, 1);
        fork
            do_req(2, 32'h80, '0, 1'b0, 4'h0);
            do_req(3, 32'h84, '0, 1'b0, 4'h0);
        join
        settle();

        // Single full-word write on port 0
        expect_txn(0, 32'h0, 32'h0023_42ab, 1'b1, 4'b1111, 2, 1'b0, '0, 1);
        do_req(0, 32'h0, 32'h0023_42ab, 1'b1, 4'b1111);
        settle();

        // Port 1 times out (stale hit follows), port 2 served afterwards
        expect_txn(1, 32'h100, '0, 1'b0, 4'h0, 0, 1'b1, '0, 1);
        expect_txn(2, 32'h104, 32'h1122_3344, 1'b1, 4'b0011, 3, 1'b0, '0, 1);
        fork
            do_req(1, 32'h100, '0, 1'b0, 4'h0);
            do_req(2, 32'h104, 32'h1122_3344, 1'b1, 4'b0011);
        join
        settle();

        // Hit lands in the watchdog expiry cycle
        expect_txn(3, 32'h180, '0, 1'b0, 4'h0, TO, 1'b0, 32'h8492_92bb, 1);
        do_req(3, 32'h180, '0, 1'b0, 4'h0);
        settle();

        // Asynchronous reset while port 2 is in ISSUE
        expect_txn(2, 32'h200, 32'h5555_aaaa, 1'b1, 4'b1000, 0, 1'b0, '0, 0);
        @(negedge clk);
        set_port(2, 32'h200, 32'h5555_aaaa, 1'b1, 4'b1000);
        begin
            int i;
            for (i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.mem_req_valid) break;
            end
            chk("pre_rst_issue", 64'(i < 20), 64'd1);
        end
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_grant_id", 64'(grant_id), 64'd0);
        chk("async_rst_mem_req_addr", 64'(bus.mem_req_addr), 64'd0);
        chk("async_rst_mem_req_wen", 64'(bus.mem_req_wen), 64'd0);
        chk("async_rst_rsp_hit", 64'(bus.rsp_hit), 64'd0);

        // After release, port 0 wins before the still-held port 2
        set_port(0, 32'h300, '0, 1'b0, 4'h0);
        expect_txn(0, 32'h300, '0, 1'b0, 4'h0, 1, 1'b0, 32'hc0de_0000, 1);
        expect_txn(2, 32'h200, 32'h5555_aaaa, 1'b1, 4'b1000, 2, 1'b0, '0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        fork
            wait_hit(0);
            wait_hit(2);
        join
        settle();

        chk("exp_iss_drained", 64'(exp_iss.size()), 64'd0);
        chk("exp_rsp_drained", 64'(exp_rsp.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
